// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants, state encoding and sizing helper for the operand sequencer
package mul_seq_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 70000;
    localparam int DEF_CNT_W   = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t START     = 3'd1;
    localparam state_t LOAD_A    = 3'd2;
    localparam state_t LOAD_B    = 3'd3;
    localparam state_t WAIT_DONE = 3'd4;

    // Counter width able to hold 0..timeout-1; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mul_seq_watchdog.sv
// rtl/mul_seq_watchdog.sv - clear/enable cycle counter flagging the last allowed wait cycle
module mul_seq_watchdog
    import mul_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - feeds operand pairs to the repeated-addition multiplier and reports outcomes
module mul_operand_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_data,
    input  logic             mul_done,
    output logic             op_done,
    output logic             op_zero,
    output logic             op_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             done_q;
    logic             op_done_q;
    logic             op_zero_q;
    logic             op_timeout_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             zero_b;
    logic             done_rise;
    logic             expired;

    assign accept    = (state == IDLE) && in_valid;
    assign zero_b    = (in_b == '0);
    // A done level carried over from an earlier operation never looks like a rising edge.
    assign done_rise = mul_done && !done_q;

    mul_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == LOAD_B),
        .en      (state == WAIT_DONE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && !zero_b) begin
                    state_nx = START;
                end
            end
            START:     state_nx = LOAD_A;
            LOAD_A:    state_nx = LOAD_B;
            LOAD_B:    state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (done_rise || expired) begin
                    state_nx = IDLE;
                end
            end
            default:   state_nx = IDLE;
        endcase
    end

    // Status flags are registered so they line up with the IDLE cycle that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            done_q       <= 1'b0;
            op_done_q    <= 1'b0;
            op_zero_q    <= 1'b0;
            op_timeout_q <= 1'b0;
            count_q      <= '0;
        end else begin
            done_q       <= mul_done;
            op_done_q    <= 1'b0;
            op_zero_q    <= 1'b0;
            op_timeout_q <= 1'b0;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
                if (zero_b) begin
                    op_done_q <= 1'b1;
                    op_zero_q <= 1'b1;
                end
            end
            if (state == WAIT_DONE) begin
                if (done_rise) begin
                    op_done_q <= 1'b1;
                    count_q   <= count_q + CNT_W'(1);
                end else if (expired) begin
                    op_done_q    <= 1'b1;
                    op_timeout_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        mul_start = (state == START);
        case (state)
            START, LOAD_A:     mul_data = a_q;
            LOAD_B, WAIT_DONE: mul_data = b_q;
            default:           mul_data = '0;
        endcase
    end

    assign op_done    = op_done_q;
    assign op_zero    = op_zero_q;
    assign op_timeout = op_timeout_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// tb/tb_mul_operand_sequencer.sv - scoreboard bench with a behavioural multiplier and outcome/latency model
module tb_mul_operand_sequencer;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 8;

    localparam int K_OK   = 0;
    localparam int K_ZERO = 1;
    localparam int K_TMO  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             mul_start;
    logic [WIDTH-1:0] mul_data;
    logic             mul_done;
    logic             op_done;
    logic             op_zero;
    logic             op_timeout;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    typedef struct {
        int kind;
        int due;
        int count;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ea_q[$];
    logic [WIDTH-1:0] eb_q[$];
    exp_t             e;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;
    int exp_count = 0;
    int last_due = 0;

    int               ph = 0;
    int               cnt = 0;
    logic             mdone_int = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mul_done = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : mdone_int;

    mul_operand_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .op_done    (op_done),
        .op_zero    (op_zero),
        .op_timeout (op_timeout),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Multiplier stand-in: start, capture A, capture B, then done rises B cycles into the wait.
    always @(negedge clk) begin
        if (!rst_n) begin
            ph        <= 0;
            cnt       <= 0;
            mdone_int <= 1'b0;
        end else if (mul_start) begin
            if (ea_q.size() == 0) fail_now("spurious_start");
            else check("start_data", mul_data, ea_q[0]);
            ph        <= 1;
            mdone_int <= 1'b0;
        end else begin
            case (ph)
                1: begin
                    if (ea_q.size() != 0) check("load_a_data", mul_data, ea_q[0]);
                    ph <= 2;
                end
                2: begin
                    if (eb_q.size() == 0) begin
                        fail_now("spurious_load_b");
                    end else begin
                        check("load_b_data", mul_data, eb_q[0]);
                        void'(ea_q.pop_front());
                        void'(eb_q.pop_front());
                    end
                    cnt <= int'(mul_data);
                    ph  <= 3;
                end
                3: begin
                    if (cnt == 0) begin
                        mdone_int <= 1'b1;
                        ph        <= 0;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_vs_busy", in_ready, !busy);
            if (!busy) begin
                check("idle_data", mul_data, 0);
                check("idle_start", mul_start, 0);
            end
            if (op_done) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_op_done");
                end else begin
                    e = exp_q.pop_front();
                    check("op_zero", op_zero, e.kind == K_ZERO);
                    check("op_timeout", op_timeout, e.kind == K_TMO);
                    check("done_latency", cyc, e.due);
                    check("op_count", op_count, e.count);
                    check("ready_at_done", in_ready, 1);
                end
            end else begin
                check("stray_qualifier", {op_zero, op_timeout}, 2'b00);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold,
                        output int acc);
        int   waited;
        exp_t x;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        acc = cyc;
        if (!in_ready) begin
            fail_now("accept_timeout");
        end else begin
            if (b == 0) begin
                x.kind = K_ZERO;
                x.due  = acc + 1;
            end else if (mode != 0 || int'(b) > TIMEOUT - 1) begin
                x.kind = K_TMO;
                x.due  = acc + 4 + TIMEOUT;
            end else begin
                x.kind = K_OK;
                x.due  = acc + 5 + int'(b);
                exp_count = (exp_count + 1) % (1 << CNT_W);
            end
            x.count = exp_count;
            exp_q.push_back(x);
            last_due = x.due;
            if (b != 0) begin
                ea_q.push_back(a);
                eb_q.push_back(b);
            end
        end
        @(negedge clk);
        if (!hold) begin
            in_valid = 1'b0;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
        end
    endtask

    task automatic drain();
        int waited;
        waited   = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
    endtask

    task automatic set_mode(input int m);
        drain();
        mode = m;
        @(negedge clk);
    endtask

    initial begin
        int               acc1;
        int               acc2;
        int               due1;
        int               r;
        int               m;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", mul_start, 0);
        check("rst_data", mul_data, 0);
        check("rst_done", {op_done, op_zero, op_timeout}, 0);
        check("rst_count", op_count, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        send(16'd7, 16'd5, 1'b0, acc1);
        drain();
        check("count_after_first", op_count, 1);

        send(16'd1234, 16'd0, 1'b0, acc1);
        drain();
        check("count_after_zero", op_count, 1);

        send(16'd3, 16'd4, 1'b1, acc1);
        due1 = last_due;
        send(16'd65535, 16'd2, 1'b1, acc2);
        check("b2b_accept_cycle", acc2, due1);
        drain();
        check("count_after_b2b", op_count, 3);

        send(16'd100, 16'd19, 1'b0, acc1);
        send(16'd101, 16'd20, 1'b0, acc1);
        drain();

        set_mode(1);
        send(16'd11, 16'd6, 1'b0, acc1);
        drain();
        check("count_after_stuck_low", op_count, 4);

        set_mode(0);
        send(16'd4, 16'd3, 1'b0, acc1);
        set_mode(2);
        send(16'd5, 16'd2, 1'b0, acc1);
        set_mode(0);
        check("count_after_stuck_high", op_count, 5);

        send(16'd9, 16'd15, 1'b0, acc1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", mul_data, 0);
        check("mid_rst_start", mul_start, 0);
        check("mid_rst_done", op_done, 0);
        check("mid_rst_count", op_count, 0);
        exp_q.delete();
        ea_q.delete();
        eb_q.delete();
        exp_count = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(16'd2, 16'd3, 1'b0, acc1);
        drain();
        check("count_after_reset_op", op_count, 1);

        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            m = (r < 6) ? 1 : (r < 12) ? 2 : 0;
            if (m != mode) set_mode(m);
            r = $urandom_range(0, 99);
            if (r < 12)      b = '0;
            else if (r < 20) b = WIDTH'(TIMEOUT - 1);
            else if (r < 28) b = WIDTH'($urandom_range(TIMEOUT, 60));
            else             b = WIDTH'($urandom_range(1, TIMEOUT - 2));
            a = WIDTH'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                send(a, b, 1'b1, acc1);
            end else begin
                send(a, b, 1'b0, acc1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        check("final_count", op_count, exp_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule
